id_ex_cnt_pipe: RTL and testbench
=================================

// Module: id_ex_cnt_pipe
// PURPOSE
//  ID->EX control pipeline register feeding the execute-stage control decoder.
//  Registers the decoded control bundle (ex, jump_t, slt, lui, mem/wb ctl, rd).
//  Detects load-use hazards and inserts stall bubbles. On a taken jump/branch it
//  kills the younger instructions for FLUSH_CYCLES bubbles.
//  Sits between the decode stage and the EX stage; the EX outputs drive ExCnt/ALU.
// PARAMETERS
//  LOAD_LAT      1  stall cycles inserted per load-use hazard (1..3)
//  FLUSH_CYCLES  1  bubbles forced into EX after a taken redirect (1..3)
// PORTS
//  clk           in   1  rising-edge clock
//  rst_n         in   1  asynchronous active-low reset
//  id_valid      in   1  decode slot holds a real instruction
//  id_ex         in   3  ALU/ex control from decoder
//  id_jump_t     in   2  00 none, 01 JAL, 10 JALR, 11 BRANCH
//  id_slt        in   1  set-less-than result select
//  id_lui        in   1  LUI result select
//  id_mem_read   in   1  load
//  id_mem_write  in   1  store
//  id_reg_write  in   1  writes rd
//  id_rd         in   5  destination register
//  id_rs1        in   5  source 1
//  id_rs2        in   5  source 2
//  id_uses_rs2   in   1  rs2 is read (R/S/B types)
//  ex_taken      in   1  EX resolved a redirect this cycle (JAL, JALR, taken BRANCH)
//  ex_valid      out  1  EX slot holds a real instruction
//  ex_ex, ex_jump_t, ex_slt, ex_lui, ex_mem_read, ex_mem_write, ex_reg_write,
//  ex_rd         out  3/2/1/1/1/1/1/5  registered copies of the id_* fields
//  stall_if_id   out  1  hold PC and IF/ID register this cycle (combinational)
//  flush_if_id   out  1  zero the IF/ID register this cycle (combinational)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all ex_* = 0, ex_valid=0, state=RUN, counters=0.
//    A bubble is all-zero control: ex=000, jump_t=00, rd=0, valid=0.
//  - hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//    (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
//  - taken_q = ex_taken & ex_valid. ex_taken is ignored when ex_valid=0.
//  - FSM states: RUN, STALL, FLUSH. Priority: taken_q > hazard > normal.
//  - RUN:   taken_q    -> flush_if_id=1, bubble next, FLUSH with cnt=FLUSH_CYCLES-1;
//                         go to RUN directly if FLUSH_CYCLES=1.
//           else hazard -> stall_if_id=1, bubble next, STALL with cnt=LOAD_LAT-1;
//                         go to RUN directly if LOAD_LAT=1.
//           else        -> latch id_* (valid=id_valid) next edge.
//  - STALL: stall_if_id=1, bubble next, cnt-- ; cnt==0 -> RUN.
//           taken_q cannot occur here (EX holds a bubble).
//  - FLUSH: flush_if_id=1, bubble next, cnt-- ; cnt==0 -> RUN.
//           stall_if_id=0 in FLUSH.
//  - Latency: one cycle ID->EX. stall_if_id and flush_if_id are never both 1.
//  - Every bubble is counted from the edge after detection.
//  - A load whose rd=x0 never stalls.
//  - A store (mem_read=0) never stalls.
//  - Back-to-back loads stall only on true dependence.
//  - rst_n asserted mid-STALL/FLUSH: immediate return to RUN with outputs zeroed.
// TESTING
//  - Reset: rst_n=0 with random id_* -> all ex_*=0, stall=flush=0; after release
//    ex_* follow id_* one cycle later.
//  - Load-use: lw x5 then add x6,x5,x1 (LOAD_LAT=1) -> stall_if_id=1 for 1 cycle,
//    ex_valid=0 for one cycle, then add appears in EX with ex_rd=6.
//  - No false hazard: lw x0 then add x6,x0,x0 -> no stall.
//    lw x5 then addi using rs2=x5 with uses_rs2=0 -> no stall.
//  - Taken JAL (FLUSH_CYCLES=2): ex_taken=1, ex_jump_t=01 -> flush_if_id=1 two cycles,
//    two bubbles (ex_valid=0, ex_ex=000), then normal flow.
//  - Simultaneous: taken_q and hazard in the same cycle -> flush wins, stall_if_id=0.
//    ex_taken with ex_valid=0 -> ignored.
//  - Mid-op reset: assert rst_n=0 during STALL (LOAD_LAT=3) -> outputs zero at once;
//    after release, RUN with no residual stall.

Source files
------------

// File: rtl/id_ex_cnt_pipe.sv
// ID->EX control pipeline register with load-use stall and redirect flush.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_*                            decoded control bundle and source regs from ID
//   ex_taken                        EX resolved a redirect this cycle
//   ex_*                            registered control bundle presented to EX
//   stall_if_id                     hold PC and IF/ID this cycle (combinational)
//   flush_if_id                     zero IF/ID this cycle (combinational)
module id_ex_cnt_pipe #(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_ex,
    input  logic [1:0] id_jump_t,
    input  logic       id_slt,
    input  logic       id_lui,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       id_reg_write,
    input  logic [4:0] id_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       ex_taken,
    output logic       ex_valid,
    output logic [2:0] ex_ex,
    output logic [1:0] ex_jump_t,
    output logic       ex_slt,
    output logic       ex_lui,
    output logic       ex_mem_read,
    output logic       ex_mem_write,
    output logic       ex_reg_write,
    output logic [4:0] ex_rd,
    output logic       stall_if_id,
    output logic       flush_if_id
);

    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hazard;
    logic             redirect;
    logic             load_id;

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // A redirect only counts when EX holds a real instruction.
    assign redirect = ex_taken & ex_valid;

    // Next-state, bubble counter and IF/ID control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        load_id     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    flush_if_id = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (hazard) begin
                    stall_if_id = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_W'(LOAD_LAT - 1);
                    end
                end else begin
                    load_id = 1'b1;
                end
            end
            ST_STALL: begin
                stall_if_id = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_if_id = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and bubble counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX control register: copy of ID or an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_ex        <= 3'd0;
            ex_jump_t    <= 2'd0;
            ex_slt       <= 1'b0;
            ex_lui       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= 5'd0;
        end else if (load_id) begin
            ex_valid     <= id_valid;
            ex_ex        <= id_ex;
            ex_jump_t    <= id_jump_t;
            ex_slt       <= id_slt;
            ex_lui       <= id_lui;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_reg_write <= id_reg_write;
            ex_rd        <= id_rd;
        end else begin
            ex_valid     <= 1'b0;
            ex_ex        <= 3'd0;
            ex_jump_t    <= 2'd0;
            ex_slt       <= 1'b0;
            ex_lui       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= 5'd0;
        end
    end

endmodule

// File: tb/tb_id_ex_cnt_pipe.sv
// Bench for id_ex_cnt_pipe: u_a (LOAD_LAT=1, FLUSH_CYCLES=2) runs a vector
// table, u_b (LOAD_LAT=3, FLUSH_CYCLES=1) covers long stalls and mid-stall reset.
module tb_id_ex_cnt_pipe;

    typedef struct packed {
        logic       valid;
        logic [2:0] ex;
        logic [1:0] jt;
        logic       slt;
        logic       lui;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [4:0] rd;
    } ex_t;

    typedef struct {
        ex_t        f;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       urs2;
        logic       tk;
        logic       es;
        logic       ef;
        logic       el;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_slt, id_lui, id_mem_read, id_mem_write, id_reg_write;
    logic       id_uses_rs2, ex_taken;
    logic [2:0] id_ex;
    logic [1:0] id_jump_t;
    logic [4:0] id_rd, id_rs1, id_rs2;

    logic       a_valid, a_slt, a_lui, a_mr, a_mw, a_rw, a_stall, a_flush;
    logic [2:0] a_ex;
    logic [1:0] a_jt;
    logic [4:0] a_rd;
    logic       b_valid, b_slt, b_lui, b_mr, b_mw, b_rw, b_stall, b_flush;
    logic [2:0] b_ex;
    logic [1:0] b_jt;
    logic [4:0] b_rd;

    ex_t a_out, b_out;
    assign a_out = {a_valid, a_ex, a_jt, a_slt, a_lui, a_mr, a_mw, a_rw, a_rd};
    assign b_out = {b_valid, b_ex, b_jt, b_slt, b_lui, b_mr, b_mw, b_rw, b_rd};

    int errors = 0;
    int checks = 0;
    ex_t exp_q[$];
    vec_t vecs[27];

    always #5 clk = ~clk;

    id_ex_cnt_pipe #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex(id_ex),
        .id_jump_t(id_jump_t), .id_slt(id_slt), .id_lui(id_lui),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_taken(ex_taken),
        .ex_valid(a_valid), .ex_ex(a_ex), .ex_jump_t(a_jt), .ex_slt(a_slt),
        .ex_lui(a_lui), .ex_mem_read(a_mr), .ex_mem_write(a_mw),
        .ex_reg_write(a_rw), .ex_rd(a_rd), .stall_if_id(a_stall),
        .flush_if_id(a_flush)
    );

    id_ex_cnt_pipe #(.LOAD_LAT(3), .FLUSH_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex(id_ex),
        .id_jump_t(id_jump_t), .id_slt(id_slt), .id_lui(id_lui),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_taken(ex_taken),
        .ex_valid(b_valid), .ex_ex(b_ex), .ex_jump_t(b_jt), .ex_slt(b_slt),
        .ex_lui(b_lui), .ex_mem_read(b_mr), .ex_mem_write(b_mw),
        .ex_reg_write(b_rw), .ex_rd(b_rd), .stall_if_id(b_stall),
        .flush_if_id(b_flush)
    );

    function automatic ex_t ins(input logic [2:0] ex, input logic [1:0] jt,
                                input logic slt, input logic lui, input logic mr,
                                input logic mw, input logic rw, input logic [4:0] rd);
        ins = {1'b1, ex, jt, slt, lui, mr, mw, rw, rd};
    endfunction

    function automatic ex_t op_add(input logic [4:0] rd);
        op_add = ins(3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd);
    endfunction

    function automatic ex_t op_lw(input logic [4:0] rd);
        op_lw = ins(3'b001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rd);
    endfunction

    function automatic vec_t mk(input ex_t f, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic urs2, input logic tk, input logic es,
                                input logic ef, input logic el);
        vec_t v;
        v.f = f; v.rs1 = rs1; v.rs2 = rs2; v.urs2 = urs2; v.tk = tk;
        v.es = es; v.ef = ef; v.el = el;
        mk = v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input ex_t f, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic urs2, input logic tk);
        id_valid = f.valid; id_ex = f.ex; id_jump_t = f.jt; id_slt = f.slt;
        id_lui = f.lui; id_mem_read = f.mr; id_mem_write = f.mw;
        id_reg_write = f.rw; id_rd = f.rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs2 = urs2; ex_taken = tk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_t sw9, slt7, lui3, jal1, nop, e;
        sw9  = ins(3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9);
        slt7 = ins(3'b011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        lui3 = ins(3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
        jal1 = ins(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        nop  = '0;

        //             instr        rs1 rs2 u  tk  stall flush latch
        vecs[0]  = mk(op_add(5'd1),  2,  3, 1, 0, 0, 0, 1);
        vecs[1]  = mk(op_lw(5'd5),   1,  0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(op_add(5'd6),  5,  1, 1, 0, 1, 0, 0);
        vecs[3]  = mk(op_add(5'd6),  5,  1, 1, 0, 0, 0, 1);
        vecs[4]  = mk(op_lw(5'd0),   2,  0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(op_add(5'd6),  0,  0, 1, 0, 0, 0, 1);
        vecs[6]  = mk(op_lw(5'd5),   1,  0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(slt7,          2,  5, 0, 0, 0, 0, 1);
        vecs[8]  = mk(sw9,           5,  7, 1, 0, 0, 0, 1);
        vecs[9]  = mk(op_add(5'd8),  9,  9, 1, 0, 0, 0, 1);
        vecs[10] = mk(op_lw(5'd10),  1,  0, 0, 0, 0, 0, 1);
        vecs[11] = mk(op_lw(5'd11),  2,  0, 0, 0, 0, 0, 1);
        vecs[12] = mk(op_lw(5'd12), 11,  0, 0, 0, 1, 0, 0);
        vecs[13] = mk(op_lw(5'd12), 11,  0, 0, 0, 0, 0, 1);
        vecs[14] = mk(op_add(5'd13), 1, 12, 1, 0, 1, 0, 0);
        vecs[15] = mk(op_add(5'd13), 1, 12, 1, 0, 0, 0, 1);
        vecs[16] = mk(op_lw(5'd14),  1,  0, 0, 0, 0, 0, 1);
        vecs[17] = mk(nop,          14, 14, 1, 0, 0, 0, 1);
        vecs[18] = mk(jal1,          0,  0, 0, 0, 0, 0, 1);
        vecs[19] = mk(op_add(5'd2),  1,  1, 1, 1, 0, 1, 0);
        vecs[20] = mk(op_add(5'd2),  1,  1, 1, 0, 0, 1, 0);
        vecs[21] = mk(lui3,          0,  0, 0, 0, 0, 0, 1);
        vecs[22] = mk(op_lw(5'd5),   1,  0, 0, 0, 0, 0, 1);
        vecs[23] = mk(op_add(5'd6),  5,  1, 1, 1, 0, 1, 0);
        vecs[24] = mk(op_add(5'd6),  5,  1, 1, 0, 0, 1, 0);
        vecs[25] = mk(op_add(5'd4),  5,  5, 1, 1, 0, 0, 1);
        vecs[26] = mk(op_add(5'd1),  4,  0, 0, 0, 0, 0, 1);

        // Reset with random ID inputs and a pending redirect request.
        rst_n = 1'b0;
        drive(ex_t'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_ex", a_out, 16'h0);
        chk("reset_a_ctl", {14'd0, a_stall, a_flush}, 16'h0);
        chk("reset_b_ex", b_out, 16'h0);
        chk("reset_b_ctl", {14'd0, b_stall, b_flush}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: drive at negedge, check IF/ID control, scoreboard EX one edge later.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(vecs[i].f, vecs[i].rs1, vecs[i].rs2, vecs[i].urs2, vecs[i].tk);
            exp_q.push_back(vecs[i].el ? vecs[i].f : ex_t'(0));
            #1;
            chk($sformatf("v%0d_stall", i), {15'd0, a_stall}, {15'd0, vecs[i].es});
            chk($sformatf("v%0d_flush", i), {15'd0, a_flush}, {15'd0, vecs[i].ef});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_ex", i), a_out, e);
        end

        // Fresh start for u_b.
        @(negedge clk);
        rst_n = 1'b0;
        drive(nop, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD_LAT=3: three stall cycles with bubbles, then the consumer.
        @(negedge clk);
        drive(op_lw(5'd5), 1, 0, 0, 0);
        #1 chk("b_lw_nostall", {15'd0, b_stall}, 16'd0);
        @(posedge clk);
        #1 chk("b_lw_ex", b_out, op_lw(5'd5));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(op_add(5'd6), 5, 1, 1, 0);
            #1 chk($sformatf("b_stall%0d", k), {15'd0, b_stall}, 16'd1);
            chk($sformatf("b_noflush%0d", k), {15'd0, b_flush}, 16'd0);
            @(posedge clk);
            #1 chk($sformatf("b_bubble%0d", k), b_out, 16'h0);
        end
        @(negedge clk);
        #1 chk("b_stall_done", {15'd0, b_stall}, 16'd0);
        @(posedge clk);
        #1 chk("b_add_ex", b_out, op_add(5'd6));

        // Reset asserted while u_b is in the middle of a stall.
        @(negedge clk);
        drive(op_lw(5'd5), 1, 0, 0, 0);
        @(negedge clk);
        drive(op_add(5'd6), 5, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        #1 chk("b_mid_stall", {15'd0, b_stall}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("b_rst_stall", {15'd0, b_stall}, 16'd0);
        chk("b_rst_ex", b_out, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("b_post_rst_nostall", {15'd0, b_stall}, 16'd0);
        @(posedge clk);
        #1 chk("b_post_rst_ex", b_out, op_add(5'd6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
